// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with a single-entry valid/ready handshake.
// Writeback data is forwarded into operands at capture and also while an entry is stalled.
module id_ex_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [DATA_WIDTH-1:0] id_rs1_data,
    input  logic [DATA_WIDTH-1:0] id_rs2_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic                  id_ALUsrc,
    input  logic [2:0]            id_ALUctrl,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_RegWrite,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [DATA_WIDTH-1:0] ex_in0,
    output logic [DATA_WIDTH-1:0] ex_in1,
    output logic [2:0]            ex_ALUctrl,
    output logic [DATA_WIDTH-1:0] ex_rs2_data,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_RegWrite
);

    logic                  valid_q;
    logic [REG_ADDR_W-1:0] rs1_q;
    logic [REG_ADDR_W-1:0] rs2_q;
    logic [DATA_WIDTH-1:0] rs1_val_q;
    logic [DATA_WIDTH-1:0] rs2_val_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic                  alusrc_q;
    logic [2:0]            aluctrl_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  regwrite_q;

    logic                  accept;
    logic                  hold;
    logic                  wb_live;
    logic [DATA_WIDTH-1:0] rs1_fwd;
    logic [DATA_WIDTH-1:0] rs2_fwd;

    always_comb begin
        id_ready = !valid_q || ex_ready;
        accept   = id_valid && id_ready && !flush;
        hold     = valid_q && !ex_ready && !flush;
        wb_live  = wb_en && (wb_rd != '0);
        rs1_fwd  = (wb_live && (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
        rs2_fwd  = (wb_live && (wb_rd == id_rs2)) ? wb_data : id_rs2_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_val_q  <= '0;
            rs2_val_q  <= '0;
            imm_q      <= '0;
            alusrc_q   <= 1'b0;
            aluctrl_q  <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q    <= 1'b1;
            rs1_q      <= id_rs1;
            rs2_q      <= id_rs2;
            rs1_val_q  <= rs1_fwd;
            rs2_val_q  <= rs2_fwd;
            imm_q      <= id_imm;
            alusrc_q   <= id_ALUsrc;
            aluctrl_q  <= id_ALUctrl;
            rd_q       <= id_rd;
            regwrite_q <= id_RegWrite;
        end else if (hold) begin
            // Stalled entry keeps its source indices so late writebacks still land.
            if (wb_live && (wb_rd == rs1_q)) rs1_val_q <= wb_data;
            if (wb_live && (wb_rd == rs2_q)) rs2_val_q <= wb_data;
        end else if (ex_ready) begin
            valid_q <= 1'b0;
        end
    end

    always_comb begin
        ex_valid    = valid_q;
        ex_in0      = rs1_val_q;
        ex_in1      = alusrc_q ? imm_q : rs2_val_q;
        ex_ALUctrl  = aluctrl_q;
        ex_rs2_data = rs2_val_q;
        ex_rd       = rd_q;
        ex_RegWrite = regwrite_q && valid_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: reset, throughput, backpressure,
// capture forwarding, stall snoop and flush.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_ALUsrc;
    logic [2:0]  id_ALUctrl;
    logic        id_RegWrite;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_in0, ex_in1, ex_rs2_data;
    logic [2:0]  ex_ALUctrl;
    logic [4:0]  ex_rd;
    logic        ex_RegWrite;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_ALUsrc(id_ALUsrc), .id_ALUctrl(id_ALUctrl),
        .id_rd(id_rd), .id_RegWrite(id_RegWrite),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_in0(ex_in0), .ex_in1(ex_in1), .ex_ALUctrl(ex_ALUctrl),
        .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic src,
                         input logic [2:0] ctrl, input logic [4:0] rd, input logic rw);
        id_valid    = 1'b1;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rs1_data = d1;
        id_rs2_data = d2;
        id_imm      = imm;
        id_ALUsrc   = src;
        id_ALUctrl  = ctrl;
        id_rd       = rd;
        id_RegWrite = rw;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        drive(5'd1, 5'd2, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b0, 3'd6, 5'd9, 1'b1);

        // Reset with live input traffic
        step(); step();
        check("rst_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_in0", ex_in0, 32'd0);
        check("rst_in1", ex_in1, 32'd0);
        check("rst_rs2", ex_rs2_data, 32'd0);
        check("rst_ctrl", {29'd0, ex_ALUctrl}, 32'd0);
        check("rst_rd", {27'd0, ex_rd}, 32'd0);
        check("rst_rw", {31'd0, ex_RegWrite}, 32'd0);
        check("rst_ready", {31'd0, id_ready}, 32'd1);

        // Back-to-back throughput
        rst_n = 1'b1; ex_ready = 1'b1;
        drive(5'd1, 5'd2, 32'd10, 32'd20, 32'd0, 1'b0, 3'd0, 5'd3, 1'b1);
        step();
        check("tp_a_valid", {31'd0, ex_valid}, 32'd1);
        check("tp_a_in0", ex_in0, 32'd10);
        check("tp_a_in1", ex_in1, 32'd20);
        check("tp_a_rd", {27'd0, ex_rd}, 32'd3);
        check("tp_a_rw", {31'd0, ex_RegWrite}, 32'd1);
        drive(5'd4, 5'd5, 32'd11, 32'd21, 32'd0, 1'b0, 3'd0, 5'd6, 1'b1);
        step();
        check("tp_b_valid", {31'd0, ex_valid}, 32'd1);
        check("tp_b_in0", ex_in0, 32'd11);
        check("tp_b_in1", ex_in1, 32'd21);
        check("tp_b_rd", {27'd0, ex_rd}, 32'd6);
        drive(5'd8, 5'd9, 32'd12, 32'd22, 32'd0, 1'b0, 3'd0, 5'd10, 1'b0);
        step();
        check("tp_c_valid", {31'd0, ex_valid}, 32'd1);
        check("tp_c_in0", ex_in0, 32'd12);
        check("tp_c_rd", {27'd0, ex_rd}, 32'd10);
        check("tp_c_rw", {31'd0, ex_RegWrite}, 32'd0);
        id_valid = 1'b0;
        step();
        check("tp_drain", {31'd0, ex_valid}, 32'd0);

        // Backpressure: A held for 4 cycles while B waits
        drive(5'd1, 5'd2, 32'h111, 32'h222, 32'h333, 1'b1, 3'd2, 5'd4, 1'b1);
        step();
        ex_ready = 1'b0;
        drive(5'd3, 5'd4, 32'h444, 32'h555, 32'h666, 1'b0, 3'd3, 5'd7, 1'b1);
        #1;
        check("bp_ready_low", {31'd0, id_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_hold_valid", {31'd0, ex_valid}, 32'd1);
            check("bp_hold_in0", ex_in0, 32'h111);
            check("bp_hold_in1", ex_in1, 32'h333);
            check("bp_hold_rs2", ex_rs2_data, 32'h222);
            check("bp_hold_ctrl", {29'd0, ex_ALUctrl}, 32'd2);
            check("bp_hold_ready", {31'd0, id_ready}, 32'd0);
        end
        ex_ready = 1'b1;
        step();
        check("bp_b_valid", {31'd0, ex_valid}, 32'd1);
        check("bp_b_in0", ex_in0, 32'h444);
        check("bp_b_in1", ex_in1, 32'h555);
        check("bp_b_rd", {27'd0, ex_rd}, 32'd7);
        id_valid = 1'b0;
        step();
        check("bp_drain", {31'd0, ex_valid}, 32'd0);

        // Capture forwarding, then index 0 never forwarded
        drive(5'd5, 5'd9, 32'h55, 32'h99, 32'd0, 1'b0, 3'd1, 5'd1, 1'b1);
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        step();
        check("fwd_in0", ex_in0, 32'hDEAD_BEEF);
        check("fwd_rs2_untouched", ex_rs2_data, 32'h99);
        drive(5'd0, 5'd6, 32'h77, 32'h66, 32'd0, 1'b0, 3'd1, 5'd1, 1'b1);
        wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        step();
        check("fwd_x0_in0", ex_in0, 32'h77);
        drive(5'd3, 5'd6, 32'h33, 32'h66, 32'd0, 1'b0, 3'd1, 5'd1, 1'b1);
        wb_rd = 5'd6; wb_data = 32'hCAFE_0006;
        step();
        check("fwd_rs2", ex_rs2_data, 32'hCAFE_0006);
        check("fwd_rs2_in1", ex_in1, 32'hCAFE_0006);
        wb_en = 1'b0;

        // Snoop into stalled entry, ALUsrc=0
        drive(5'd3, 5'd7, 32'h30, 32'h10, 32'hAAAA, 1'b0, 3'd0, 5'd2, 1'b1);
        step();
        id_valid = 1'b0; ex_ready = 1'b0;
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234;
        step();
        check("snp_in1", ex_in1, 32'h1234);
        check("snp_rs2", ex_rs2_data, 32'h1234);
        check("snp_in0_kept", ex_in0, 32'h30);
        wb_en = 1'b0; ex_ready = 1'b1;
        step();
        check("snp_drain", {31'd0, ex_valid}, 32'd0);

        // Snoop with ALUsrc=1: in1 stays imm, store data updates
        drive(5'd3, 5'd7, 32'h30, 32'h10, 32'hAAAA, 1'b1, 3'd0, 5'd2, 1'b1);
        step();
        id_valid = 1'b0; ex_ready = 1'b0;
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h5678;
        step();
        check("snp_imm_in1", ex_in1, 32'hAAAA);
        check("snp_imm_rs2", ex_rs2_data, 32'h5678);
        wb_en = 1'b0;

        // Flush on held entry with a competing incoming entry
        flush = 1'b1;
        drive(5'd1, 5'd2, 32'hBAD, 32'hBAD, 32'hBAD, 1'b0, 3'd4, 5'd31, 1'b1);
        step();
        check("fl_valid", {31'd0, ex_valid}, 32'd0);
        check("fl_rw", {31'd0, ex_RegWrite}, 32'd0);
        flush = 1'b0; id_valid = 1'b0;
        step();
        check("fl_no_ghost", {31'd0, ex_valid}, 32'd0);

        // ALUctrl 7 passes through unchanged
        ex_ready = 1'b1;
        drive(5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 1'b0, 3'd7, 5'd8, 1'b1);
        step();
        check("ctrl7", {29'd0, ex_ALUctrl}, 32'd7);
        check("ctrl7_valid", {31'd0, ex_valid}, 32'd1);
        id_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
